// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, instruction-memory requests and {instr,pc} fetch buffer with redirect flush
module instr_fetch_unit #(
  parameter int PC_W = 19,
  parameter int INSTR_W = 19,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [PC_W-1:0]         out_pc,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic [$clog2(DEPTH):0]  fetch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [PC_W-1:0] pc, inflight_pc;
  logic inflight, push, pop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0] pc_q [DEPTH];
  // credit counts the outstanding request so a returning word always has a slot
  assign imem_req = reset & ~redirect_valid & (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign imem_addr = pc;
  assign out_valid = (count != '0) & ~redirect_valid;
  assign out_instr = instr_q[rd_ptr];
  assign out_pc = pc_q[rd_ptr];
  assign fetch_count = count;
  assign push = inflight & ~redirect_valid;
  assign pop = out_valid & out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc <= pc + PC_W'(1);
        inflight_pc <= pc;
      end
      if (push) begin
        instr_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr] <= inflight_pc;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front-end for the 19-bit CPU. It holds the program counter, issues word reads to the synchronous instruction memory, and buffers returned 19-bit instructions in a small FIFO. It presents each instruction with its PC to the downstream decode/execute stage over a valid/ready handshake. Branch and jump redirects from execute flush the buffer and restart fetch at the target.

## Interface
- `PC_W`, default 19: program-counter width; word-addressed.
- `INSTR_W`, default 19: instruction width.
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  PC_W  word address for the request.
- `imem_rdata`  in  INSTR_W  read data; valid exactly one cycle after the request cycle.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts this cycle.
- `out_instr`  out  INSTR_W  instruction at FIFO head.
- `out_pc`  out  PC_W  PC of `out_instr`.
- `redirect_valid`  in  1  taken branch or jump; flush and refetch.
- `redirect_pc`  in  PC_W  redirect target.
- `fetch_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- State:
  - `pc`: next fetch address.
  - `inflight`: 1-bit; a request was issued last cycle.
  - FIFO of {instr, pc} pairs, with read pointer, write pointer and count.
  - `inflight_pc`: PC of the outstanding request.
- Issue rule: `imem_req = reset & ~redirect_valid & (count + inflight < DEPTH)`.
  - Count is the registered value; a same-cycle pop is not credited.
  - `imem_addr = pc`.
  - On issue: `pc <= pc + 1` (modulo 2^PC_W), `inflight <= 1`, `inflight_pc <= pc`.
  - Otherwise: `inflight <= 0`.
- Response: when `inflight` is 1 and `redirect_valid` is 0, push {`imem_rdata`, `inflight_pc`} into the FIFO at the clock edge. The credit rule guarantees the FIFO never overflows.
- Output:
  - `out_valid = (count != 0) & ~redirect_valid`.
  - `out_instr` and `out_pc` show the head entry.
  - Pop on `out_valid & out_ready`.
  - When push and pop occur in the same cycle, count is unchanged.
- Redirect (`redirect_valid` high in cycle k), applied at the closing edge:
  - `pc <= redirect_pc`.
  - FIFO emptied; pointers and count go to 0.
  - `inflight <= 0`.
  - The response arriving in cycle k is discarded.
  - No request is issued in cycle k.
  - Redirect has priority over push, pop and issue.
- Back-to-back redirects: the last one wins. Each redirect cycle suppresses issue and output.
- Reset values (while `reset` is low):
  - `pc = RESET_PC`, `inflight = 0`, FIFO empty.
  - `imem_req = 0`, `out_valid = 0`, `fetch_count = 0`.
  - `out_instr` and `out_pc` are 0; the storage array is cleared.
- Reset mid-operation: all in-flight and buffered instructions are lost. No response is accepted in the first cycle after reset release.

## Timing
- Memory contract: the request is sampled at edge E_k, and `imem_rdata` is valid throughout cycle k+1.
- Fetch latency: request in cycle k, then `out_valid` high in cycle k+2 (registered FIFO, no bypass).
- First instruction after reset release: request in the first cycle with `reset` high (cycle 0); `out_valid` in cycle 2 with `out_pc = RESET_PC`.
- Redirect latency: redirect in cycle k, new request in k+1, target instruction valid in k+3.
- Sustained throughput with `out_ready` held high: one instruction per cycle, no bubbles (occupancy settles at 1, inflight at 1).
- With `out_ready` held low: exactly DEPTH requests are issued, then `imem_req` stays 0 until a pop is registered.
- Combinational paths: `redirect_valid` to `out_valid`, and `redirect_valid` to `imem_req`. No path from `out_ready` to `imem_req`.

## Test plan
- Reset/streaming:
  - Stimulus: memory returns `addr ^ 19'h5A5A5`, `out_ready=1`, reset released before cycle 0.
  - Required: `out_valid` first high in cycle 2 with `out_pc=0`, `out_instr=19'h5A5A5`; then consecutive PCs 1, 2, 3…, one per cycle.
- Backpressure:
  - Stimulus: `out_ready=0` from reset.
  - Required: exactly 4 requests (addresses 0–3), `fetch_count` reaches 4, `imem_req` then stays 0.
  - Stimulus: raise `out_ready` for one cycle.
  - Required: PC 0 popped; request for address 4 issued the following cycle.
- Redirect while streaming:
  - Stimulus: `redirect_valid=1`, `redirect_pc=19'h00100` in cycle 10.
  - Required: `out_valid=0` in cycles 10–12; `imem_req=0` in cycle 10; `imem_addr=19'h00100` in cycle 11; `out_pc=19'h00100` in cycle 13; no pre-redirect PC ever appears afterwards.
- Wrap-around:
  - Stimulus: redirect to `19'h7FFFE`.
  - Required: delivered PCs `19'h7FFFE`, `19'h7FFFF`, `19'h00000`, `19'h00001`.
- Simultaneous events:
  - Stimulus: redirect asserted in the same cycle as an accepted pop and a returning response.
  - Required: FIFO empty afterwards, response dropped, `fetch_count=0`; a second redirect in the next cycle overrides the first target.
- Asynchronous reset mid-stream:
  - Stimulus: drive `reset` low between clock edges during cycle 20.
  - Required: `imem_req`, `out_valid` and `fetch_count` go to 0 immediately; after release, fetch restarts at `RESET_PC` with the cycle-2 latency.
